// File: rtl/rr_output_arbiter_pkg.sv
// rtl/rr_output_arbiter_pkg.sv - shared port indices, sizes and FSM encoding for the output arbiter
package rr_output_arbiter_pkg;

  localparam int NPORTS_DEF      = 5;
  localparam int PTR_W_DEF       = 3;
  localparam int WDOG_CYCLES_DEF = 256;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_output_arbiter_pick.sv
// rtl/rr_output_arbiter_pick.sv - combinational round-robin picker (rr_pick)
// Rotates the request vector so ptr sits at bit 0, isolates the lowest set bit, rotates back.
module rr_pick #(
  parameter int NPORTS = 5,
  parameter int PTR_W  = 3
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NPORTS-1:0] onehot_o,
  output logic              any_o
);

  logic [2*NPORTS-1:0] req2;
  logic [2*NPORTS-1:0] oh2;
  logic [NPORTS-1:0]   rot;
  logic [NPORTS-1:0]   rot_oh;

  always_comb begin
    req2     = {req_i, req_i};
    rot      = req2[ptr_i +: NPORTS];
    rot_oh   = rot & (~rot + {{(NPORTS-1){1'b0}}, 1'b1});
    oh2      = {{NPORTS{1'b0}}, rot_oh} << ptr_i;
    onehot_o = oh2[NPORTS-1:0] | oh2[2*NPORTS-1:NPORTS];
    any_o    = |req_i;
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - per-output wormhole arbiter, head-to-tail lock, round-robin between packets
// Optional stall watchdog with forced release enabled by defining ARB_WATCHDOG_EN.
module rr_output_arbiter
  import rr_output_arbiter_pkg::*;
#(
  parameter int NPORTS      = NPORTS_DEF,
  parameter int PTR_W       = PTR_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] tail,
  input  logic              out_ready,
  output logic [NPORTS-1:0] grant,
  output logic              fire,
  output logic              wdog_err
);

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [NPORTS-1:0] pick_oh;
  logic              pick_any;
  logic [PTR_W-1:0]  owner_idx;
  logic [PTR_W-1:0]  owner_next;
  logic              owner_tail;
  logic              wdog_hit;

  rr_pick #(.NPORTS(NPORTS), .PTR_W(PTR_W)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .any_o    (pick_any)
  );

  assign grant      = grant_q;
  assign fire       = (|(grant_q & req)) & out_ready;
  assign owner_tail = |(grant_q & tail);

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
    owner_next = (owner_idx == PTR_W'(NPORTS-1)) ? '0 : owner_idx + 1'b1;
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign wdog_hit = (state_q == ST_LOCKED) && !fire && (cnt_q == CNT_W'(WDOG_CYCLES-1));
  assign wdog_err = err_q;

  // Cleared on any transfer and whenever the lock is dropped; saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | wdog_hit;
    if (state_q != ST_LOCKED || fire || wdog_hit) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(WDOG_CYCLES-1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && out_ready) begin
          grant_d = pick_oh;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if ((fire && owner_tail) || wdog_hit) begin
          grant_d = '0;
          state_d = ST_IDLE;
          ptr_d   = owner_next;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - directed vectors plus per-cycle reference model for rr_output_arbiter
module tb_rr_output_arbiter;

  localparam int N  = 5;
  localparam int WD = 8;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] grant;
  logic         fire;
  logic         wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  rr_output_arbiter #(.NPORTS(N), .PTR_W(3), .WDOG_CYCLES(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .grant     (grant),
    .fire      (fire),
    .wdog_err  (wdog_err)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = free), next-priority port, stall count, sticky error.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit found;
    bit f;
    int idx;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_stall = 0; m_err = 1'b0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (out_ready) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && req[idx]) begin
            m_owner = idx;
            found = 1'b1;
          end
        end
      end
    end else begin
      f = req[m_owner] && out_ready;
      if (f && tail[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_stall = 0;
      end else if (f) begin
        m_stall = 0;
      end else if (WD_EN && m_stall == WD - 1) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_stall = 0; m_err = 1'b1;
      end else begin
        m_stall = m_stall + 1;
      end
    end
  end

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model grant", 32'(grant), 32'(m_grant()));
      chk("model fire", 32'(fire), 32'((m_owner >= 0) && req[m_owner] && out_ready));
      chk("model wdog_err", 32'(wdog_err), 32'(m_err));
    end
  end

  task automatic vec(input string nm, input logic [N-1:0] r, input logic [N-1:0] t,
                     input logic o, input logic [N-1:0] eg, input logic ef, input logic ew);
    req = r; tail = t; out_ready = o;
    #1;
    chk({nm, " grant"}, 32'(grant), 32'(eg));
    chk({nm, " fire"}, 32'(fire), 32'(ef));
    chk({nm, " wdog_err"}, 32'(wdog_err), 32'(ew));
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    req = '0; tail = '0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset wdog_err", 32'(wdog_err), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  logic [N-1:0] rr_exp [0:10];

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("por grant", 32'(grant), 32'h0);
    chk("por fire", 32'(fire), 32'h0);
    rst = 1'b0;

    // 1: async reset mid-packet, then ptr must be back at 0
    vec("t1 arb",   5'b00100, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t1 flit",  5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b0);
    req = 5'b00100; rst = 1'b1;
    #1;
    chk("t1 async grant", 32'(grant), 32'h0);
    chk("t1 async fire", 32'(fire), 32'h0);
    chk("t1 async wdog", 32'(wdog_err), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    vec("t1 rearb", 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t1 ptr0",  5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b0);

    // 2: single contender, ptr moves to 3
    do_reset();
    vec("t2 arb",   5'b00100, 5'b00100, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t2 fire",  5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b0);
    vec("t2 rel",   5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t2 arb2",  5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t2 ptr3",  5'b00000, 5'b00000, 1'b1, 5'b01000, 1'b0, 1'b0);

    // 3: full round-robin with one bubble between packets
    do_reset();
    rr_exp = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100,
               5'b00000, 5'b01000, 5'b00000, 5'b10000, 5'b00000};
    for (int i = 0; i < 11; i++)
      vec("t3 rr", 5'b11111, 5'b11111, 1'b1, rr_exp[i], rr_exp[i] != 5'b0, 1'b0);
    vec("t3 wrap", 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b0);

    // 4: wormhole hold through credit stall and req bubble
    do_reset();
    vec("t4 arb",   5'b01010, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t4 f1",    5'b01010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      vec("t4 nocr", 5'b01010, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b0);
    vec("t4 f2",    5'b01010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0);
    vec("t4 gap",   5'b01000, 5'b00000, 1'b1, 5'b00010, 1'b0, 1'b0);
    vec("t4 f3",    5'b01010, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b0);
    vec("t4 tail",  5'b01010, 5'b00010, 1'b1, 5'b00010, 1'b1, 1'b0);
    vec("t4 bub",   5'b01000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t4 next",  5'b01000, 5'b00000, 1'b1, 5'b01000, 1'b1, 1'b0);

    // 5: no credit, no arbitration
    do_reset();
    for (int i = 0; i < 5; i++)
      vec("t5 nocr", 5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b0, 1'b0);
    vec("t5 arb",   5'b10000, 5'b10000, 1'b1, 5'b00000, 1'b0, 1'b0);
    vec("t5 gnt",   5'b10000, 5'b10000, 1'b1, 5'b10000, 1'b1, 1'b0);

    // 6: stall timeout (forced release only with the watchdog built in)
    do_reset();
    vec("t6 arb",   5'b00001, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < WD; i++)
      vec("t6 stall", 5'b00001, 5'b00000, 1'b0, 5'b00001, 1'b0, 1'b0);
    if (WD_EN) begin
      vec("t6 rel",   5'b00011, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b1);
      vec("t6 ptr1",  5'b00011, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b1);
      vec("t6 stick", 5'b00011, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b1);
    end else begin
      vec("t6 hold",  5'b00011, 5'b00000, 1'b0, 5'b00001, 1'b0, 1'b0);
      vec("t6 hold2", 5'b00011, 5'b00000, 1'b1, 5'b00001, 1'b1, 1'b0);
    end
    do_reset();
    chk("t6 err clr", 32'(wdog_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
